array_job_arbiter: RTL

Shares one systolic-array compute slot (array scheduler + PE grid) between up to NUM_REQ requesters. Picks one requester by round-robin and re-arms the array scheduler with a one-cycle clear. It then holds the scheduler's enable until the scheduler reports done, and returns a one-cycle completion (with error flag on timeout) to the owner. Sits between the requester ports (weight/activation feeders) and the array scheduler's `reset`/`general_enable`/`done` pins.

---
 rtl/array_job_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/array_job_arbiter.sv
// array_job_arbiter: round-robin owner of one systolic-array slot with clear/run/timeout job sequencing
module array_job_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       array_clear,
    output logic                       array_enable,
    input  logic                       array_done,
    output logic [NUM_REQ-1:0]         cmpl,
    output logic                       cmpl_err,
    output logic                       busy,
    output logic [CNT_W-1:0]           jobs_done
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int RUN_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [ID_W-1:0]    rr_ptr, rr_n, owner_n, pick;
    logic [RUN_W-1:0]   run_cnt, cnt_n;
    logic               err, err_n;
    logic [NUM_REQ-1:0] gnt_n, cmpl_n;
    logic               clear_n, enable_n, cmpl_err_n, busy_n;
    logic [CNT_W-1:0]   jobs_n;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        onehot = '0;
        onehot[id] = 1'b1;
    endfunction

    // Round-robin pick: walk offsets high to low so the lowest offset from rr_ptr wins
    always_comb begin
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[(int'(rr_ptr) + i) % NUM_REQ]) pick = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_n    = state;
        owner_n    = owner_id;
        rr_n       = rr_ptr;
        cnt_n      = run_cnt;
        err_n      = err;
        jobs_n     = jobs_done;
        gnt_n      = gnt;
        busy_n     = busy;
        clear_n    = 1'b0;
        enable_n   = 1'b0;
        cmpl_n     = '0;
        cmpl_err_n = 1'b0;
        case (state)
            IDLE: if (|req) begin
                state_n = CLEAR;
                owner_n = pick;
                gnt_n   = onehot(pick);
                clear_n = 1'b1;
                busy_n  = 1'b1;
            end
            CLEAR: begin
                state_n  = RUN;
                cnt_n    = RUN_W'(1);
                enable_n = 1'b1;
            end
            RUN: if (array_done || run_cnt == RUN_W'(TIMEOUT)) begin
                state_n    = DONE;
                err_n      = !array_done;
                cmpl_n     = onehot(owner_id);
                cmpl_err_n = !array_done;
            end else begin
                cnt_n    = run_cnt + RUN_W'(1);
                enable_n = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                gnt_n   = '0;
                busy_n  = 1'b0;
                jobs_n  = jobs_done + CNT_W'(1);
                rr_n    = (owner_id == ID_W'(NUM_REQ - 1)) ? '0 : owner_id + ID_W'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset aborts any job in flight without a completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            owner_id     <= '0;
            rr_ptr       <= '0;
            run_cnt      <= '0;
            err          <= 1'b0;
            jobs_done    <= '0;
            gnt          <= '0;
            busy         <= 1'b0;
            array_clear  <= 1'b0;
            array_enable <= 1'b0;
            cmpl         <= '0;
            cmpl_err     <= 1'b0;
        end else begin
            state        <= state_n;
            owner_id     <= owner_n;
            rr_ptr       <= rr_n;
            run_cnt      <= cnt_n;
            err          <= err_n;
            jobs_done    <= jobs_n;
            gnt          <= gnt_n;
            busy         <= busy_n;
            array_clear  <= clear_n;
            array_enable <= enable_n;
            cmpl         <= cmpl_n;
            cmpl_err     <= cmpl_err_n;
        end
    end

endmodule
